// File: rtl/pool_window_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pool_window_buffer
// Description : Gathers a raster-order activation stream into non-overlapping
//               2x2 windows for the max-pooling stage, using one line buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module pool_window_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int FM_WIDTH   = 28,
    parameter int FM_HEIGHT  = 28
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      in_valid,
    input  logic [DATA_WIDTH-1:0]     in_data,
    output logic [4*DATA_WIDTH-1:0]   ifm_window,
    output logic                      pooling_signal,
    output logic                      frame_done,
    output logic                      busy
);

    if ((FM_WIDTH < 2) || ((FM_WIDTH % 2) != 0)) begin : g_bad_width
        $error("pool_window_buffer: FM_WIDTH must be even and >= 2");
    end
    if ((FM_HEIGHT < 2) || ((FM_HEIGHT % 2) != 0)) begin : g_bad_height
        $error("pool_window_buffer: FM_HEIGHT must be even and >= 2");
    end

    localparam int c_col_w = $clog2(FM_WIDTH);
    localparam int c_row_w = $clog2(FM_HEIGHT);
    localparam logic [c_col_w-1:0] c_col_last = c_col_w'(FM_WIDTH - 1);
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(FM_HEIGHT - 1);

    localparam logic [0:0] c_st_top    = 1'b0;
    localparam logic [0:0] c_st_bottom = 1'b1;

    logic [c_col_w-1:0]       r_col_cnt;
    logic [c_row_w-1:0]       r_row_cnt;
    logic [0:0]               r_state;
    logic [DATA_WIDTH-1:0]    r_hold;
    logic [DATA_WIDTH-1:0]    r_line_buf [FM_WIDTH];
    logic [4*DATA_WIDTH-1:0]  r_window;
    logic                     r_pool;
    logic                     r_done;

    logic                     w_accept;
    logic                     w_col_wrap;
    logic                     w_row_wrap;
    logic                     w_emit;
    logic                     w_last;
    logic [c_col_w-1:0]       w_col_prev;

    // clear takes priority over a pixel presented on the same cycle
    assign w_accept   = in_valid & ~clear;
    assign w_col_wrap = (r_col_cnt == c_col_last);
    assign w_row_wrap = (r_row_cnt == c_row_last);
    assign w_emit     = w_accept && (r_state == c_st_bottom) && r_col_cnt[0];
    assign w_last     = w_emit && w_col_wrap && w_row_wrap;
    assign w_col_prev = r_col_cnt - c_col_w'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_cnt <= '0;
            r_row_cnt <= '0;
            r_state   <= c_st_top;
            r_hold    <= '0;
            r_window  <= '0;
            r_pool    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_pool <= w_emit;
            r_done <= w_last;
            if (w_emit) begin
                r_window <= {in_data, r_hold, r_line_buf[r_col_cnt], r_line_buf[w_col_prev]};
            end
            if (clear) begin
                r_col_cnt <= '0;
                r_row_cnt <= '0;
                r_state   <= c_st_top;
                r_hold    <= '0;
            end else if (in_valid) begin
                if ((r_state == c_st_bottom) && !r_col_cnt[0]) begin
                    r_hold <= in_data;
                end
                if (w_col_wrap) begin
                    r_col_cnt <= '0;
                    if (w_row_wrap) begin
                        r_row_cnt <= '0;
                        r_state   <= c_st_top;
                    end else begin
                        r_row_cnt <= r_row_cnt + c_row_w'(1);
                        r_state   <= ~r_state;
                    end
                end else begin
                    r_col_cnt <= r_col_cnt + c_col_w'(1);
                end
            end
        end
    end

    // Storage only; contents are don't-care after reset so no reset branch
    always_ff @(posedge clk) begin
        if (w_accept && (r_state == c_st_top)) begin
            r_line_buf[r_col_cnt] <= in_data;
        end
    end

    assign ifm_window     = r_window;
    assign pooling_signal = r_pool;
    assign frame_done     = r_done;
    assign busy           = (r_col_cnt != '0) || (r_row_cnt != '0);

endmodule
`default_nettype wire
